// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the picorv32 native-bus interconnect.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          MAX_SLAVES        = 8;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module mem_bus_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [31:0]              m_addr,
  input  logic [32*NUM_SLAVES-1:0] slave_base,
  input  logic [32*NUM_SLAVES-1:0] slave_mask,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx
);

  logic [NUM_SLAVES-1:0] hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
      assign hit_vec[gi] = (m_addr & slave_mask[32*gi +: 32]) == slave_base[32*gi +: 32];
    end
  endgenerate

  // Scan downwards so the lowest hitting index is the last one written.
  always_comb begin
    hit = |hit_vec;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master, N-slave registered interconnect for the picorv32 native bus,
// with per-access timeout and a sticky record of unmapped or hung accesses.
module mem_bus_fabric
  import mem_bus_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = {32'h4000_0000, 32'h2000_0000,
                                                     32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK = {4{32'hFF00_0000}},
  parameter int                        TIMEOUT    = 64,
  parameter logic [31:0]               ERR_RDATA  = DEFAULT_ERR_RDATA
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m_valid,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic                     err_clear,
  output logic                     err_valid,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   sel_reg, sel_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [31:0]        rdata_q, rdata_next;
  logic               err_q, err_next;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic               err_event;

  mem_bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_decode (
    .m_addr     (m_addr),
    .slave_base (SLAVE_BASE),
    .slave_mask (SLAVE_MASK),
    .hit        (dec_hit),
    .idx        (dec_idx)
  );

  // Only the selected slave's ready/rdata are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    timer_next = timer_reg;
    rdata_next = rdata_q;
    err_next   = err_q;
    case (state_reg)
      IDLE: begin
        if (m_valid) begin
          if (dec_hit) begin
            sel_next   = dec_idx;
            timer_next = '0;
            state_next = WAIT;
          end else begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      WAIT: begin
        timer_next = timer_reg + 1'b1;
        // A master that drops its request abandons the access silently.
        if (!m_valid) begin
          state_next = IDLE;
        end else if (sel_ready) begin
          rdata_next = sel_rdata;
          err_next   = 1'b0;
          state_next = DONE;
        end else if ((TIMEOUT != 0) && (timer_reg == TIMER_W'(TIMEOUT - 1))) begin
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign err_event = (state_reg != DONE) && (state_next == DONE) && err_next;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      timer_reg <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      timer_reg <= timer_next;
      rdata_q   <= rdata_next;
      err_q     <= err_next;
      // A new error in the same cycle as a clear reloads the record.
      if (err_event) begin
        if (err_clear || !err_valid) begin
          err_valid <= 1'b1;
          err_addr  <= m_addr;
        end
        if (err_clear) begin
          err_count <= 8'd1;
        end else if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end else if (err_clear) begin
        err_valid <= 1'b0;
        err_addr  <= '0;
        err_count <= '0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sval
      assign s_valid[gi] = (state_reg == WAIT) && (sel_reg == IDX_W'(gi));
    end
  endgenerate

  assign m_ready = (state_reg == DONE);
  assign m_rdata = err_q ? ERR_RDATA : rdata_q;
  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Randomised scoreboard bench for mem_bus_fabric: five slaves (slave 4 overlaps
// slave 0), short timeout, error record, abort and reset-in-flight cases.
module tb_mem_bus_fabric;

  localparam int          NS   = 5;
  localparam int          TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [32*NS-1:0] P_BASE = {32'h0000_0000, 32'h4000_0000, 32'h2000_0000,
                                         32'h1000_0000, 32'h0000_0000};
  localparam logic [32*NS-1:0] P_MASK = {32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000,
                                         32'hFF00_0000, 32'hFF00_0000};

  logic [31:0] ref_base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000,
                                 32'h4000_0000, 32'h0000_0000};
  logic [31:0] ref_mask [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
                                 32'hFF00_0000, 32'hF000_0000};

  logic            clk, resetn;
  logic            m_valid;
  logic [31:0]     m_addr, m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_ready;
  logic [31:0]     m_rdata;
  logic [NS-1:0]   s_valid;
  logic [31:0]     s_addr, s_wdata;
  logic [3:0]      s_wstrb;
  logic [NS-1:0]   s_ready;
  logic [32*NS-1:0] s_rdata;
  logic            err_clear;
  logic            err_valid;
  logic [31:0]     err_addr;
  logic [7:0]      err_count;

  mem_bus_fabric #(
    .NUM_SLAVES (NS),
    .SLAVE_BASE (P_BASE),
    .SLAVE_MASK (P_MASK),
    .TIMEOUT    (TO),
    .ERR_RDATA  (ERRD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .err_clear (err_clear),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          t0;
    int          lat;
    logic        ev;
    logic [31:0] ea;
    int          ec;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          t0      = 0;
  int          sv_end  = -1;
  int          cur_idx = -1;
  int          cur_lat = 0;
  logic [31:0] cur_data = '0;
  bit          busy    = 0;
  bit          mon_en  = 0;
  // reference error record
  logic        m_ev = 0;
  logic [31:0] m_ea = '0;
  int          m_ec = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & ref_mask[i]) == ref_base[i]) return i;
    end
    return -1;
  endfunction

  // Slave side: the expected slave answers after cur_lat cycles; everything else is noise.
  initial begin
    s_ready = '0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      s_ready = NS'($urandom);
      for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = $urandom;
      if (busy && cur_idx >= 0) begin
        s_ready[cur_idx] = (cur_lat > 0) && (cyc - t0 == cur_lat);
        if (s_ready[cur_idx]) s_rdata[32*cur_idx +: 32] = cur_data;
      end
    end
  end

  // Monitor: checks select/pass-through every cycle and pops the scoreboard on m_ready.
  initial begin : monitor
    exp_t          e;
    logic [NS-1:0] exp_sv;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_sv = '0;
        if (cur_idx >= 0 && cyc > t0 && cyc <= sv_end) exp_sv[cur_idx] = 1'b1;
        check("s_valid", 72'(s_valid), 72'(exp_sv));
        check("passthru", 72'({s_addr, s_wdata, s_wstrb}), 72'({m_addr, m_wdata, m_wstrb}));
        if (m_ready !== 1'b0) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_m_ready: got %b expected 0 (cycle %0d)", m_ready, cyc);
          end else begin
            e = sb.pop_front();
            check("latency", 72'(cyc - e.t0), 72'(e.lat));
            check("m_rdata", 72'(m_rdata), 72'(e.rdata));
            check("err_valid", 72'(err_valid), 72'(e.ev));
            check("err_addr", 72'(err_addr), 72'(e.ea));
            check("err_count", 72'(err_count), 72'(e.ec));
            $display("[TB] txn addr=%08h lat=%0d rdata=%08h err_count=%0d", e.addr, cyc - e.t0,
                     m_rdata, err_count);
          end
        end
      end
    end
  end

  // Issue one access (called at posedge+1); lat 0 means the slave never answers.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input int lat, input logic [31:0] data, input bit clr, input int gap);
    exp_t e;
    int   idx;
    bit   err;
    bit   got;
    idx = ref_decode(a);
    err = (idx < 0) || (lat < 1) || (lat > TO);
    e.lat   = (idx < 0) ? 1 : (err ? TO + 1 : lat + 1);
    e.rdata = err ? ERRD : data;
    if (clr) begin
      m_ev = 0;
      m_ea = '0;
      m_ec = 0;
    end
    if (err) begin
      if (m_ec < 255) m_ec++;
      if (!m_ev) begin
        m_ev = 1;
        m_ea = a;
      end
    end
    e.addr = a;
    e.t0   = cyc;
    e.ev   = m_ev;
    e.ea   = m_ea;
    e.ec   = m_ec;
    sb.push_back(e);
    t0       = cyc;
    cur_idx  = idx;
    cur_lat  = lat;
    cur_data = data;
    sv_end   = (idx < 0) ? t0 : t0 + e.lat - 1;
    busy     = 1;
    m_valid  = 1;
    m_addr   = a;
    m_wdata  = wd;
    m_wstrb  = ws;
    err_clear = clr;
    @(posedge clk);
    #1;
    err_clear = 0;
    got = 0;
    for (int n = 0; n < TO + 8 && !got; n++) begin
      @(negedge clk);
      if (m_ready === 1'b1) got = 1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_timeout: addr=%08h got no m_ready expected one", a);
      sb.delete();
    end
    m_valid = 0;
    busy    = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a mapped access that the slave never answers, then either drop
  // m_valid (abort) or pulse reset in the second WAIT cycle.
  task automatic interrupted(input logic [31:0] a, input bit use_reset);
    cur_idx = ref_decode(a);
    cur_lat = 0;
    t0      = cyc;
    sv_end  = t0 + 2;
    busy    = 1;
    m_valid = 1;
    m_addr  = a;
    m_wstrb = 4'b0000;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    if (use_reset) resetn = 0;
    else m_valid = 0;
    @(posedge clk);
    #1;
    resetn  = 1;
    m_valid = 0;
    busy    = 0;
    if (use_reset) begin
      m_ev = 0;
      m_ea = '0;
      m_ec = 0;
    end
    @(negedge clk);
    check(use_reset ? "rst_err_valid" : "abort_err_valid", 72'(err_valid), 72'(m_ev));
    check(use_reset ? "rst_err_addr" : "abort_err_addr", 72'(err_addr), 72'(m_ea));
    check(use_reset ? "rst_err_count" : "abort_err_count", 72'(err_count), 72'(m_ec));
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [7:0] tops [8] = '{8'h00, 8'h07, 8'h10, 8'h20, 8'h40, 8'h30, 8'h50, 8'hFF};
    logic [31:0] a;
    resetn    = 0;
    m_valid   = 0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    err_clear = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_ready", 72'(m_ready), 72'(1'b0));
    check("reset_s_valid", 72'(s_valid), 72'(0));
    check("reset_m_rdata", 72'(m_rdata), 72'(0));
    check("reset_err_valid", 72'(err_valid), 72'(1'b0));
    check("reset_err_addr", 72'(err_addr), 72'(0));
    check("reset_err_count", 72'(err_count), 72'(0));
    @(posedge clk);
    #1;
    resetn = 1;
    mon_en = 1;

    txn(32'h2000_0010, 32'h0, 4'b0000, 2, 32'h1234_5678, 0, 1);
    txn(32'h1000_0004, 32'hCAFE_F00D, 4'b0011, 1, $urandom, 0, 0);
    txn(32'h3000_0000, 32'h0, 4'b0000, 1, $urandom, 0, 0);
    txn(32'h5000_0000, 32'h0, 4'b0000, 1, $urandom, 0, 1);
    check("first_err_addr_kept", 72'(err_addr), 72'(32'h3000_0000));
    txn(32'h0000_0100, 32'h0, 4'b0000, 0, $urandom, 0, 0);   // slave 0 hangs
    txn(32'h0000_0104, 32'h0, 4'b0000, TO, 32'hA5A5_0004, 0, 0);
    txn(32'h0000_0108, 32'h0, 4'b0000, TO + 1, $urandom, 0, 0);
    txn(32'h0000_0040, 32'h0, 4'b0000, 3, 32'h0BAD_0040, 0, 0); // overlap -> slave 0
    txn(32'h0700_0000, 32'h11, 4'b1111, 2, 32'h4444_0700, 0, 0); // slave 4 only
    txn(32'h4012_3456, 32'h0, 4'b0000, 1, 32'h4040_4040, 0, 0);
    txn(32'h3100_0000, 32'h0, 4'b0000, 1, $urandom, 1, 0);   // clear with new error
    check("clr_err_addr", 72'(err_addr), 72'(32'h3100_0000));

    err_clear = 1;
    @(posedge clk);
    #1;
    err_clear = 0;
    m_ev = 0;
    m_ea = '0;
    m_ec = 0;
    @(negedge clk);
    check("clear_err_valid", 72'(err_valid), 72'(1'b0));
    check("clear_err_count", 72'(err_count), 72'(0));
    @(posedge clk);
    #1;

    txn(32'h6000_0000, 32'h0, 4'b0000, 1, $urandom, 0, 0);
    interrupted(32'h2000_0200, 0);
    interrupted(32'h1000_0300, 1);

    for (int i = 0; i < 260; i++) begin
      txn(32'h6000_0000 + 32'(i), 32'h0, 4'b0000, 1, $urandom, 0, 0);
    end
    check("saturated_count", 72'(err_count), 72'(8'd255));

    for (int i = 0; i < 200; i++) begin
      a = {tops[$urandom_range(0, 7)], 24'($urandom)};
      txn(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
          $urandom_range(0, 6), $urandom, ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 72'(sb.size()), 72'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
